uart_tx_scheduler: RTL

Two-requester scheduler and byte sequencer in front of the UART transmitter. It arbitrates round-robin between two message sources, latches the winning M-bit message, and feeds the UART TX one N-bit character at a time, MSB character first, over a start/busy handshake. It sits between the application logic (calculator result formatter, status reporter) and the UART TX module; it is the only master of the TX.

---
 rtl/uart_tx_scheduler_pkg.sv | 28 ++
 rtl/uart_tx_scheduler_if.sv | 38 +++
 rtl/uart_tx_scheduler_rr_arbiter_2.sv | 27 ++
 rtl/uart_tx_scheduler.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART TX scheduler slice.
// Holds the FSM state encoding, default character/message widths,
// the NUL character constant, the grant encoding and a counter-width helper.
package uart_tx_scheduler_pkg;

   localparam int unsigned N_DEFAULT = 8;
   localparam int unsigned M_DEFAULT = 128;

   localparam logic [7:0] NUL = 8'h00;

   localparam logic GRANT_A = 1'b0;
   localparam logic GRANT_B = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_SEND      = 3'd2,
      ST_WAIT_ACK  = 3'd3,
      ST_WAIT_IDLE = 3'd4,
      ST_DONE      = 3'd5
   } state_t;

   // Character-counter width; at least one bit even for single-character messages.
   function automatic int unsigned cnt_width(input int unsigned bytes);
      return (bytes > 1) ? $clog2(bytes) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Bundle of the scheduler's requester and UART TX handshake signals.
//   req_a/req_b   : level requests from the two message sources
//   msg_a/msg_b   : M-bit messages, first character in [M-1:M-N]
//   ack_a/ack_b   : one-cycle pulse when the message is latched
//   tx_busy       : UART TX busy flag
//   tx_start      : one-cycle launch pulse, tx_data : character to send
//   grant         : owner of current/last message (0 = A, 1 = B)
//   busy / done   : scheduler activity flag / end-of-message pulse
// Modport master is the scheduler side, slave is the surrounding logic.
interface uart_tx_scheduler_if #(
   parameter int unsigned N = uart_tx_scheduler_pkg::N_DEFAULT,
   parameter int unsigned M = uart_tx_scheduler_pkg::M_DEFAULT
);

   logic         req_a;
   logic [M-1:0] msg_a;
   logic         ack_a;
   logic         req_b;
   logic [M-1:0] msg_b;
   logic         ack_b;
   logic         tx_busy;
   logic         tx_start;
   logic [N-1:0] tx_data;
   logic         grant;
   logic         busy;
   logic         done;

   modport master (
      input  req_a, msg_a, req_b, msg_b, tx_busy,
      output ack_a, ack_b, tx_start, tx_data, grant, busy, done
   );

   modport slave (
      output req_a, msg_a, req_b, msg_b, tx_busy,
      input  ack_a, ack_b, tx_start, tx_data, grant, busy, done
   );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter_2.sv
// Two-way round-robin pick.
//   req_a, req_b : requests
//   last_grant   : previous winner (0 = A, 1 = B)
//   winner_c     : selected requester, meaningful when valid_c = 1
//   valid_c      : at least one request present
// On a tie the requester that did not win last time is chosen.
module rr_arbiter_2
   import uart_tx_scheduler_pkg::*;
(
   input  logic req_a,
   input  logic req_b,
   input  logic last_grant,
   output logic winner_c,
   output logic valid_c
);

   always_comb begin
      valid_c  = req_a | req_b;
      winner_c = GRANT_A;
      if (req_a && req_b) begin
         winner_c = ~last_grant;
      end else if (req_b) begin
         winner_c = GRANT_B;
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Two-requester scheduler and character sequencer in front of the UART TX.
// Arbitrates round-robin between requesters A and B, latches the winning
// M-bit message and feeds it to the TX N bits at a time, MSB character first.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : uart_tx_scheduler_if.master (requests, acks, TX handshake,
//                grant/busy/done status)
// Build option: TXSEQ_SKIP_NUL_EN - when defined, 0x00 characters are not
// launched; the sequencer spends one SEND cycle on each and moves on.
module uart_tx_scheduler
   import uart_tx_scheduler_pkg::*;
#(
   parameter int unsigned N = N_DEFAULT,
   parameter int unsigned M = M_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   uart_tx_scheduler_if.master   bus
);

   localparam int unsigned BYTES = M / N;
   localparam int unsigned CNT_W = cnt_width(BYTES);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES - 1);

`ifdef TXSEQ_SKIP_NUL_EN
   localparam bit SKIP_NUL = 1'b1;
`else
   localparam bit SKIP_NUL = 1'b0;
`endif

   state_t           state;
   logic [M-1:0]     shreg;
   logic [CNT_W-1:0] cnt;
   logic             last_grant;

   logic             winner_c;
   logic             valid_c;
   logic [M-1:0]     msg_sel_c;
   logic [M-1:0]     shreg_shift_c;
   logic [N-1:0]     cur_char_c;
   logic [N-1:0]     next_char_c;
   logic             last_char_c;

   rr_arbiter_2 u_arb (
      .req_a      (bus.req_a),
      .req_b      (bus.req_b),
      .last_grant (last_grant),
      .winner_c   (winner_c),
      .valid_c    (valid_c)
   );

   // A character is launched unless NUL skipping is enabled and it is NUL.
   function automatic logic launch_ok(input logic [N-1:0] c);
      return !SKIP_NUL || (c != N'(NUL));
   endfunction

   // Datapath views: selected message, next shifted register, head characters.
   always_comb begin
      msg_sel_c     = (winner_c == GRANT_B) ? bus.msg_b : bus.msg_a;
      shreg_shift_c = shreg << N;
      cur_char_c    = shreg[M-1 -: N];
      next_char_c   = shreg_shift_c[M-1 -: N];
      last_char_c   = (cnt == LAST_IDX);
   end

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         shreg        <= '0;
         cnt          <= '0;
         last_grant   <= GRANT_B;
         bus.ack_a    <= 1'b0;
         bus.ack_b    <= 1'b0;
         bus.tx_start <= 1'b0;
         bus.tx_data  <= '0;
         bus.grant    <= GRANT_A;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
      end else begin
         bus.ack_a    <= 1'b0;
         bus.ack_b    <= 1'b0;
         bus.tx_start <= 1'b0;
         bus.done     <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (valid_c) begin
                  shreg      <= msg_sel_c;
                  cnt        <= '0;
                  bus.grant  <= winner_c;
                  last_grant <= winner_c;
                  bus.ack_a  <= (winner_c == GRANT_A);
                  bus.ack_b  <= (winner_c == GRANT_B);
                  bus.busy   <= 1'b1;
                  state      <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               if (!bus.tx_busy) begin
                  bus.tx_start <= launch_ok(cur_char_c);
                  bus.tx_data  <= cur_char_c;
                  state        <= ST_SEND;
               end
            end

            // tx_start high here means the character went out; otherwise it was skipped.
            ST_SEND: begin
               if (bus.tx_start) begin
                  state <= ST_WAIT_ACK;
               end else if (last_char_c) begin
                  bus.done <= 1'b1;
                  state    <= ST_DONE;
               end else begin
                  shreg        <= shreg_shift_c;
                  cnt          <= cnt + CNT_W'(1);
                  bus.tx_start <= launch_ok(next_char_c);
                  bus.tx_data  <= next_char_c;
                  state        <= ST_SEND;
               end
            end

            // A TX that never raises busy parks the sequencer here until reset.
            ST_WAIT_ACK: begin
               if (bus.tx_busy) begin
                  state <= ST_WAIT_IDLE;
               end
            end

            ST_WAIT_IDLE: begin
               if (!bus.tx_busy) begin
                  if (last_char_c) begin
                     bus.done <= 1'b1;
                     state    <= ST_DONE;
                  end else begin
                     shreg        <= shreg_shift_c;
                     cnt          <= cnt + CNT_W'(1);
                     bus.tx_start <= launch_ok(next_char_c);
                     bus.tx_data  <= next_char_c;
                     state        <= ST_SEND;
                  end
               end
            end

            ST_DONE: begin
               bus.busy <= 1'b0;
               state    <= ST_IDLE;
            end

            default: begin
               bus.busy <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
